// File: rtl/mult_unit_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// FSM encodings, default operand width and counter-width helper.
package mult_unit_pkg;

    localparam int MULT_WIDTH = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mult_unit_add32.sv
// WIDTH-bit ripple-carry adder built from a chain of full-adder cells.
// Carry-in is tied low; the carry-out feeds the multiplier's accumulate.
module add_full (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));
endmodule

module add32 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    logic [WIDTH:0] c;

    assign c[0] = 1'b0;
    assign cout = c[WIDTH];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        add_full u_fa (
            .x  (x[i]),
            .y  (y[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end
endmodule

// File: rtl/mult_unit.sv
// Sequential signed/unsigned multiplier for mult/multu: magnitudes are
// multiplied by shift-and-add over WIDTH cycles, then the sign is applied.
module mult_unit
    import mult_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int               CW    = cnt_width(WIDTH);
    localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE_W = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_P = (2*WIDTH)'(1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   ma;
    logic               neg;

    logic [WIDTH-1:0]   a_mag, b_mag, sum, upper;
    logic               cout, carry, accept;
    logic [2*WIDTH-1:0] res;

    // Magnitudes stay unsigned WIDTH bits, so the most-negative value maps to itself.
    assign a_mag  = (is_signed && a[WIDTH-1]) ? (~a + ONE_W) : a;
    assign b_mag  = (is_signed && b[WIDTH-1]) ? (~b + ONE_W) : b;
    assign accept = start && (state == ST_IDLE || state == ST_DONE);

    add32 #(.WIDTH(WIDTH)) u_add (
        .x    (p[2*WIDTH-1:WIDTH]),
        .y    (ma),
        .sum  (sum),
        .cout (cout)
    );

    assign upper = p[0] ? sum : p[2*WIDTH-1:WIDTH];
    assign carry = p[0] & cout;
    assign res   = neg ? (~p + ONE_P) : p;

    assign busy = (state == ST_CALC) || (state == ST_FIX);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            p     <= '0;
            ma    <= '0;
            neg   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_CALC: begin
                    p   <= {carry, upper, p[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) state <= ST_FIX;
                end
                ST_FIX: begin
                    {hi, lo} <= res;
                    state    <= ST_DONE;
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    if (accept) begin
                        ma    <= a_mag;
                        neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                        p     <= {{WIDTH{1'b0}}, b_mag};
                        cnt   <= '0;
                        state <= ST_CALC;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: directed operations push expected
// {cycle, hi, lo}; a monitor pops and checks on every done pulse.
module tb_mult_unit;
    localparam int W = 32;

    typedef struct {
        int          cyc;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset, start, is_signed;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    mult_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("hi", 64'(hi), 64'(e.hi));
                check("lo", 64'(lo), 64'(e.lo));
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives start for one cycle; returns the cycle in which start was high.
    task automatic issue(input logic sg, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic expect_it, input logic [W-1:0] eh, input logic [W-1:0] el,
                         output int s);
        exp_t e;
        start = 1'b1; is_signed = sg; a = x; b = y;
        s = cyc;
        if (expect_it) begin
            e.cyc = s + W + 2; e.hi = eh; e.lo = el;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0; a = '0; b = '0; is_signed = 1'b0;
    endtask

    task automatic run_op(input logic sg, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] eh, input logic [W-1:0] el);
        int s;
        issue(sg, x, y, 1'b1, eh, el, s);
        wait_cyc(s + W + 4);
    endtask

    initial begin
        int s;
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // 3 x 5 with busy profile over the whole operation
        issue(1'b0, 32'd3, 32'd5, 1'b1, 32'h0, 32'hF, s);
        for (int k = 1; k <= W + 2; k++) begin
            wait_cyc(s + k);
            @(negedge clk);
            check("busy_profile", 64'(busy), (k <= W + 1) ? 64'd1 : 64'd0);
            if (k == W + 1) check("no_early_done", 64'(done), 64'd0);
        end
        wait_cyc(s + W + 6);
        @(negedge clk);
        check("hold_lo", 64'(lo), 64'hF);
        check("idle_done", 64'(done), 64'd0);

        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op(1'b1, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op(1'b1, 32'd5,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFDD);
        run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        run_op(1'b0, 32'h8000_0000, 32'd2,         32'h0000_0001, 32'h0000_0000);
        run_op(1'b1, 32'd0,         32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000);
        run_op(1'b0, 32'h1234_5678, 32'h10,        32'h0000_0001, 32'h2345_6780);

        // Ignored mid-flight start, then back-to-back start in DONE
        begin
            int s1, s2;
            issue(1'b0, 32'h1234_5678, 32'h10, 1'b1, 32'h1, 32'h2345_6780, s1);
            wait_cyc(s1 + 10);
            issue(1'b0, 32'd9, 32'd9, 1'b0, 32'h0, 32'h0, s2);
            wait_cyc(s1 + W + 2);
            issue(1'b0, 32'd7, 32'd6, 1'b1, 32'h0, 32'h2A, s2);
            check("b2b_start_cycle", 64'(s2), 64'(s1 + W + 2));
            wait_cyc(s2 + W + 4);
        end

        // Reset mid-CALC aborts the operation
        issue(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'h0, 32'h0, s);
        wait_cyc(s + 12);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        wait_cyc(s + 2 * W + 8);

        run_op(1'b0, 32'd3, 32'd5, 32'h0, 32'hF);

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout: cycle %0d reached without finishing", cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
